// File: rtl/axis_chk_pkg.sv
// Shared types and helpers for the LMAC RX AXI-Stream packet checker.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BODY  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int unsigned ERR_DATA  = 0;
  localparam int unsigned ERR_STRB  = 1;
  localparam int unsigned ERR_LEN   = 2;
  localparam int unsigned ERR_TUSER = 3;
  localparam int unsigned ERR_W     = 4;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

  // Contiguous from bit 0 means the mask has the form 2^k - 1 with k > 0.
  function automatic logic strb_contig(input logic [31:0] s);
    return (s != '0) && ((s & (s + 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/axis_chk_sat_counter.sv
// Saturating accumulator with synchronous clear; clear takes priority over increment.
module axis_chk_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] amount,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {1'b0, amount};
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/axis_rx_pkt_checker.sv
// AXI-Stream sink for the LMAC RX path: applies tready backpressure, checks payload,
// tstrb, length and tuser per frame, and keeps saturating frame/byte statistics.
module axis_rx_pkt_checker
  import axis_chk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned CTRL_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned MIN_LEN    = 64,
  parameter int unsigned MAX_LEN    = 1518
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic [DATA_WIDTH-1:0] rx_axis_mac_tdata,
  input  logic                  rx_axis_mac_tvalid,
  input  logic                  rx_axis_mac_tlast,
  input  logic                  rx_axis_mac_tuser,
  input  logic [CTRL_WIDTH-1:0] rx_axis_mac_tstrb,
  output logic                  rx_axis_mac_tready,
  input  logic                  chk_en,
  input  logic                  bp_en,
  input  logic [31:0]           bp_pattern,
  input  logic                  clear_stats,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [3:0]            frame_err,
  output logic [15:0]           frame_len,
  output logic [CNT_WIDTH-1:0]  good_cnt,
  output logic [CNT_WIDTH-1:0]  bad_cnt,
  output logic [CNT_WIDTH-1:0]  byte_cnt
);

  state_e             state_q, state_d;
  logic [4:0]         bp_idx_q, bp_idx_d;
  logic [7:0]         seq_q, seq_d;
  logic [15:0]        off_q, off_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_ok_q, frame_ok_d;
  logic [ERR_W-1:0]   frame_err_q, frame_err_d;
  logic [15:0]        frame_len_q, frame_len_d;
  logic               count_en_q, count_en_d;

  logic               accept;
  logic [31:0]        strb32;
  logic [5:0]         beat_bytes;
  logic [16:0]        len17;
  logic [15:0]        len_sat;
  logic               data_bad;
  logic [ERR_W-1:0]   beat_err;
  logic [ERR_W-1:0]   err_acc;

  assign rx_axis_mac_tready = bp_en ? bp_pattern[bp_idx_q] : 1'b1;
  assign accept             = rx_axis_mac_tvalid & rx_axis_mac_tready;
  assign strb32             = 32'(rx_axis_mac_tstrb);
  assign beat_bytes         = popcount32(strb32);
  assign len17              = {1'b0, off_q} + 17'(beat_bytes);
  assign len_sat            = len17[16] ? '1 : len17[15:0];

  always_comb begin
    data_bad = 1'b0;
    for (int unsigned j = 0; j < CTRL_WIDTH; j++) begin
      if (rx_axis_mac_tstrb[j] &&
          (rx_axis_mac_tdata[8*j +: 8] != (seq_q + off_q[7:0] + 8'(j)))) begin
        data_bad = 1'b1;
      end
    end
  end

  // Draining frames already carry an error, so no further checks are applied.
  always_comb begin
    beat_err = '0;
    if (state_q != S_DRAIN) begin
      if (chk_en && data_bad) beat_err[ERR_DATA] = 1'b1;
      if (rx_axis_mac_tlast ? !strb_contig(strb32) : (rx_axis_mac_tstrb != '1)) begin
        beat_err[ERR_STRB] = 1'b1;
      end
      if (off_q > 16'(MAX_LEN)) beat_err[ERR_LEN] = 1'b1;
      if (rx_axis_mac_tlast && (len17 < 17'(MIN_LEN))) beat_err[ERR_LEN] = 1'b1;
      if (rx_axis_mac_tlast && rx_axis_mac_tuser) beat_err[ERR_TUSER] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    bp_idx_d     = bp_en ? (bp_idx_q + 5'd1) : bp_idx_q;
    seq_d        = seq_q;
    off_d        = off_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    frame_ok_d   = 1'b0;
    frame_err_d  = '0;
    frame_len_d  = '0;
    count_en_d   = 1'b0;
    err_acc      = err_q | beat_err;

    if (accept) begin
      if (rx_axis_mac_tlast) begin
        state_d      = S_IDLE;
        off_d        = '0;
        err_d        = '0;
        frame_done_d = 1'b1;
        frame_ok_d   = (err_acc == '0);
        frame_err_d  = err_acc;
        frame_len_d  = len_sat;
        count_en_d   = ~clear_stats;
        seq_d        = seq_q + 8'd1;
      end else begin
        off_d   = len_sat;
        err_d   = err_acc;
        state_d = ((state_q == S_DRAIN) || (err_acc != '0)) ? S_DRAIN : S_BODY;
      end
    end

    if (clear_stats) seq_d = '0;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= S_IDLE;
      bp_idx_q     <= '0;
      seq_q        <= '0;
      off_q        <= '0;
      err_q        <= '0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= '0;
      frame_len_q  <= '0;
      count_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bp_idx_q     <= bp_idx_d;
      seq_q        <= seq_d;
      off_q        <= off_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      frame_len_q  <= frame_len_d;
      count_en_q   <= count_en_d;
    end
  end

  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign frame_len  = frame_len_q;

  // Statistics follow the registered result; a clear on either the tlast or the
  // following cycle suppresses counting of that frame.
  axis_chk_sat_counter #(.WIDTH(CNT_WIDTH)) u_good_cnt (
    .clk    (clk),
    .rst_n  (reset_),
    .clr    (clear_stats),
    .inc    (count_en_q & frame_ok_q),
    .amount (CNT_WIDTH'(1)),
    .cnt    (good_cnt)
  );

  axis_chk_sat_counter #(.WIDTH(CNT_WIDTH)) u_bad_cnt (
    .clk    (clk),
    .rst_n  (reset_),
    .clr    (clear_stats),
    .inc    (count_en_q & ~frame_ok_q),
    .amount (CNT_WIDTH'(1)),
    .cnt    (bad_cnt)
  );

  axis_chk_sat_counter #(.WIDTH(CNT_WIDTH)) u_byte_cnt (
    .clk    (clk),
    .rst_n  (reset_),
    .clr    (clear_stats),
    .inc    (count_en_q & frame_ok_q),
    .amount (CNT_WIDTH'(frame_len_q)),
    .cnt    (byte_cnt)
  );

endmodule

// File: tb/tb_axis_rx_pkt_checker.sv
// Scoreboard bench for axis_rx_pkt_checker: frames are generated with the expected
// incrementing pattern, expected results are queued per frame and popped on frame_done.
`timescale 1ns/1ps
module tb_axis_rx_pkt_checker;

  localparam int DW = 256;
  localparam int CW = 32;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          reset_;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tuser;
  logic [CW-1:0] tstrb;
  logic          tready;
  logic          chk_en, bp_en, clear_stats;
  logic [31:0]   bp_pattern;
  logic          frame_done, frame_ok;
  logic [3:0]    frame_err;
  logic [15:0]   frame_len;
  logic [NW-1:0] good_cnt, bad_cnt, byte_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0]  err;
    logic        ok;
    logic [15:0] len;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  exp_seq;
  int unsigned exp_good, exp_bad, exp_bytes;

  always #5 clk = ~clk;

  axis_rx_pkt_checker #(
    .DATA_WIDTH (DW),
    .CTRL_WIDTH (CW),
    .CNT_WIDTH  (NW),
    .MIN_LEN    (64),
    .MAX_LEN    (1518)
  ) dut (
    .clk                (clk),
    .reset_             (reset_),
    .rx_axis_mac_tdata  (tdata),
    .rx_axis_mac_tvalid (tvalid),
    .rx_axis_mac_tlast  (tlast),
    .rx_axis_mac_tuser  (tuser),
    .rx_axis_mac_tstrb  (tstrb),
    .rx_axis_mac_tready (tready),
    .chk_en             (chk_en),
    .bp_en              (bp_en),
    .bp_pattern         (bp_pattern),
    .clear_stats        (clear_stats),
    .frame_done         (frame_done),
    .frame_ok           (frame_ok),
    .frame_err          (frame_err),
    .frame_len          (frame_len),
    .good_cnt           (good_cnt),
    .bad_cnt            (bad_cnt),
    .byte_cnt           (byte_cnt)
  );

  always @(negedge clk) begin
    if (reset_ === 1'b1 && frame_done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_frame_done got len=%0d err=%b required=no frame", frame_len, frame_err);
      end else begin
        mon_e = sb.pop_front();
        tests++;
        if (frame_ok !== mon_e.ok) begin fails++; $display("FAIL frame_ok got=%b exp=%b", frame_ok, mon_e.ok); end
        tests++;
        if (frame_err !== mon_e.err) begin fails++; $display("FAIL frame_err got=%b exp=%b", frame_err, mon_e.err); end
        tests++;
        if (frame_len !== mon_e.len) begin fails++; $display("FAIL frame_len got=%0d exp=%0d", frame_len, mon_e.len); end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic [CW-1:0] s, input logic l, input logic u);
    int unsigned waits;
    waits = 0;
    @(negedge clk);
    tdata = d; tstrb = s; tlast = l; tuser = u; tvalid = 1'b1;
    #1;
    while (tready !== 1'b1) begin
      @(negedge clk);
      #1;
      waits++;
      if (waits > 64) begin
        tests++; fails++;
        $display("FAIL tready_timeout got=%b required=1", tready);
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    exp_good = 0; exp_bad = 0; exp_bytes = 0; exp_seq = 8'd0;
  endtask

  // last_strb = 0 selects the natural contiguous mask for the final beat.
  task automatic send_frame(input int unsigned len, input logic [CW-1:0] last_strb,
                            input int corrupt, input logic user, input logic [3:0] exp_err);
    int unsigned nb, off, rem;
    logic [DW-1:0] d;
    logic [CW-1:0] s;
    exp_t e;
    nb = (len + 31) / 32;
    for (int unsigned b = 0; b < nb; b++) begin
      off = b * 32;
      for (int unsigned j = 0; j < 32; j++) begin
        d[8*j +: 8] = 8'(exp_seq + off + j);
        if (corrupt >= 0 && int'(off + j) == corrupt) d[8*j +: 8] = ~d[8*j +: 8];
      end
      if (b == nb - 1) begin
        rem = len - off;
        s = '0;
        for (int unsigned j = 0; j < 32; j++) if (j < rem) s[j] = 1'b1;
        if (last_strb != '0) s = last_strb;
        e.err = exp_err; e.ok = (exp_err == 4'd0); e.len = 16'(len);
        sb.push_back(e);
        if (e.ok) begin exp_good++; exp_bytes += len; end else exp_bad++;
        exp_seq++;
        drive_beat(d, s, 1'b1, user);
      end else begin
        drive_beat(d, '1, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    reset_ = 1'b0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tdata = '0; tstrb = '0;
    chk_en = 1'b1; bp_en = 1'b0; bp_pattern = '0; clear_stats = 1'b0;
    exp_seq = 8'd0; exp_good = 0; exp_bad = 0; exp_bytes = 0;
    repeat (3) @(negedge clk);
    tests++; if (tready !== 1'b1) begin fails++; $display("FAIL reset_tready got=%b exp=1", tready); end
    tests++; if (frame_done !== 1'b0 || frame_ok !== 1'b0) begin fails++; $display("FAIL reset_done_ok got=%b%b exp=00", frame_done, frame_ok); end
    tests++; if (frame_err !== 4'd0 || frame_len !== 16'd0) begin fails++; $display("FAIL reset_err_len got=%b/%0d exp=0000/0", frame_err, frame_len); end
    tests++; if (good_cnt !== '0 || bad_cnt !== '0 || byte_cnt !== '0) begin fails++; $display("FAIL reset_cnts got=%0d/%0d/%0d exp=0/0/0", good_cnt, bad_cnt, byte_cnt); end
    reset_ = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    send_frame(64, '0, -1, 1'b0, 4'b0000);
    idle(4);
    tests++; if (good_cnt !== 32'(exp_good) || exp_good != 1) begin fails++; $display("FAIL t1_good_cnt got=%0d exp=1", good_cnt); end
    tests++; if (byte_cnt !== 32'd64) begin fails++; $display("FAIL t1_byte_cnt got=%0d exp=64", byte_cnt); end
    tests++; if (bad_cnt !== 32'd0) begin fails++; $display("FAIL t1_bad_cnt got=%0d exp=0", bad_cnt); end
  endtask

  task automatic test_strb();
    do_clear();
    send_frame(100, '0, -1, 1'b0, 4'b0000);
    send_frame(100, 32'h0000_00F0, -1, 1'b0, 4'b0010);
    idle(4);
    tests++; if (good_cnt !== 32'd1) begin fails++; $display("FAIL t2_good_cnt got=%0d exp=1", good_cnt); end
    tests++; if (bad_cnt !== 32'd1) begin fails++; $display("FAIL t2_bad_cnt got=%0d exp=1", bad_cnt); end
    tests++; if (byte_cnt !== 32'd100) begin fails++; $display("FAIL t2_byte_cnt got=%0d exp=100", byte_cnt); end
  endtask

  task automatic test_back_to_back();
    logic prev, cur;
    do_clear();
    bp_pattern = 32'h5555_5555;
    bp_en = 1'b1;
    @(negedge clk);
    prev = tready;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cur = tready;
      tests++; if (cur === prev) begin fails++; $display("FAIL t3_tready_toggle got=%b exp=%b", cur, ~prev); end
      prev = cur;
    end
    for (int f = 0; f < 10; f++) send_frame(1518, '0, -1, 1'b0, 4'b0000);
    idle(6);
    tests++; if (good_cnt !== 32'd10) begin fails++; $display("FAIL t3_good_cnt got=%0d exp=10", good_cnt); end
    tests++; if (byte_cnt !== 32'd15180) begin fails++; $display("FAIL t3_byte_cnt got=%0d exp=15180", byte_cnt); end
    tests++; if (bad_cnt !== 32'd0) begin fails++; $display("FAIL t3_bad_cnt got=%0d exp=0", bad_cnt); end
    bp_en = 1'b0;
  endtask

  task automatic test_data_error();
    do_clear();
    for (int f = 1; f <= 5; f++) begin
      if (f == 3) send_frame(128, '0, 40, 1'b0, 4'b0001);
      else        send_frame(128, '0, -1, 1'b0, 4'b0000);
    end
    idle(4);
    tests++; if (good_cnt !== 32'd4) begin fails++; $display("FAIL t4_good_cnt got=%0d exp=4", good_cnt); end
    tests++; if (bad_cnt !== 32'd1) begin fails++; $display("FAIL t4_bad_cnt got=%0d exp=1", bad_cnt); end
    tests++; if (byte_cnt !== 32'd512) begin fails++; $display("FAIL t4_byte_cnt got=%0d exp=512", byte_cnt); end
    chk_en = 1'b0;
    send_frame(64, '0, 10, 1'b0, 4'b0000);
    idle(2);
    chk_en = 1'b1;
  endtask

  task automatic test_length();
    do_clear();
    send_frame(1600, '0, -1, 1'b0, 4'b0100);
    send_frame(32, '0, -1, 1'b1, 4'b1100);
    send_frame(63, '0, -1, 1'b0, 4'b0100);
    idle(4);
    tests++; if (bad_cnt !== 32'd3) begin fails++; $display("FAIL t5_bad_cnt got=%0d exp=3", bad_cnt); end
    tests++; if (good_cnt !== 32'd0 || byte_cnt !== 32'd0) begin fails++; $display("FAIL t5_good_bytes got=%0d/%0d exp=0/0", good_cnt, byte_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    for (int b = 0; b < 3; b++) drive_beat('0, '1, 1'b0, 1'b0);
    @(negedge clk);
    tvalid = 1'b0;
    reset_ = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (good_cnt !== '0 || bad_cnt !== '0 || byte_cnt !== '0) begin fails++; $display("FAIL t6_reset_cnts got=%0d/%0d/%0d exp=0/0/0", good_cnt, bad_cnt, byte_cnt); end
    tests++; if (tready !== 1'b1) begin fails++; $display("FAIL t6_reset_tready got=%b exp=1", tready); end
    reset_ = 1'b1;
    exp_good = 0; exp_bad = 0; exp_bytes = 0; exp_seq = 8'd0;
    @(negedge clk);
    send_frame(64, '0, -1, 1'b0, 4'b0000);
    idle(4);
    tests++; if (good_cnt !== 32'd1 || byte_cnt !== 32'd64) begin fails++; $display("FAIL t6_after_reset got=%0d/%0d exp=1/64", good_cnt, byte_cnt); end

    // Clear on the cycle that frame_done is high.
    send_frame(64, '0, -1, 1'b0, 4'b0000);
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    exp_good = 0; exp_bad = 0; exp_bytes = 0; exp_seq = 8'd0;
    idle(4);
    tests++; if (good_cnt !== '0 || bad_cnt !== '0 || byte_cnt !== '0) begin fails++; $display("FAIL t6_clear_cnts got=%0d/%0d/%0d exp=0/0/0", good_cnt, bad_cnt, byte_cnt); end
    send_frame(64, '0, -1, 1'b0, 4'b0000);
    idle(4);
    tests++; if (good_cnt !== 32'd1) begin fails++; $display("FAIL t6_seq_restart got=%0d exp=1", good_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_strb();
    test_back_to_back();
    test_data_error();
    test_length();
    test_reset_mid_frame();
    idle(5);
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
